instr_encoder: RTL and testbench

//  RV32I instruction encoder: the write-side counterpart of the instruction decode/control logic.

---
 rtl/instr_encoder.sv | 96 +++++++++
 tb/tb_instr_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into instruction words, tags each with a byte address and queues them in a FIFO.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        class_i,
  input  logic [2:0]        funct3_i,
  input  logic              alt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [20:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]       word;
  logic [11:0]       i_imm;
  logic              is_shift, bad_imm, reject, accept, push, pop;
  logic [31:0]       mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] next_addr;
  assign is_shift = class_i == 3'd1 && funct3_i[1:0] == 2'b01;
  assign i_imm = is_shift ? {1'b0, alt_i, 5'b0, imm_i[4:0]} : imm_i[11:0];
`ifdef IMM_RANGE_CHECK_EN
  logic fit12, fit13;
  assign fit12 = &imm_i[20:11] | ~|imm_i[20:11];
  assign fit13 = &imm_i[20:12] | ~|imm_i[20:12];
  assign bad_imm = (class_i inside {3'd1, 3'd2, 3'd3, 3'd6} && !fit12) ||
                   (class_i == 3'd4 && (!fit13 || imm_i[0])) ||
                   (class_i == 3'd5 && imm_i[0]) ||
                   (is_shift && |imm_i[11:5]);
`else
  assign bad_imm = 1'b0;
`endif
  assign reject = class_i == 3'd7 || bad_imm;
  always_comb begin
    word = '0;
    case (class_i)
      3'd0: word = {alt_i ? 7'h20 : 7'h00, rs2_i, rs1_i, funct3_i, rd_i, 7'h33};
      3'd1: word = {i_imm, rs1_i, funct3_i, rd_i, 7'h13};
      3'd2: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'h03};
      3'd3: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'h23};
      3'd4: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'h63};
      3'd5: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'h6F};
      3'd6: word = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'h67};
      default: word = '0;
    endcase
  end
  assign in_ready_o = count != (PW+1)'(DEPTH);
  assign out_valid_o = count != '0;
  assign accept = in_valid_i & in_ready_o;
  assign push = accept & ~reject;
  assign pop = out_valid_o & out_ready_i;
  assign out_data_o = out_valid_o ? mem_data[rd_ptr] : '0;
  assign out_addr_o = out_valid_o ? mem_addr[rd_ptr] : '0;
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= word;
      mem_addr[wr_ptr] <= next_addr;
    end
  end
  // flush clears everything reset does except the reject counter
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
      err_o     <= 1'b0;
      if (rst_i) err_cnt_o <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        next_addr <= next_addr + ADDR_W'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      err_o <= accept & reject;
      if (accept && reject && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder with a field-level reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, err, alt = 0;
  logic [2:0] cls = 0, f3 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [20:0] imm = 0;
  logic [31:0] out_data, out_addr;
  logic [7:0] err_cnt;
  typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  int tests = 0, fails = 0, mcount = 0, exp_cnt = 0;
  logic [31:0] maddr = BASE;
  bit exp_err = 0, pop_now = 0, started = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .class_i(cls), .funct3_i(f3), .alt_i(alt), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_addr_o(out_addr),
    .err_o(err), .err_cnt_o(err_cnt));

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_enc();
    logic [31:0] x, f;
    x = {{11{imm[20]}}, imm};
    f = (32'(rs1) << 15) | (32'(f3) << 12);
    case (cls)
      0: return (32'(alt) << 30) | (32'(rs2) << 20) | f | (32'(rd) << 7) | 32'h33;
      1: return (((f3 == 1 || f3 == 5) ? ((x & 32'h1F) | (32'(alt) << 10)) : (x & 32'hFFF)) << 20)
                | f | (32'(rd) << 7) | 32'h13;
      2: return ((x & 32'hFFF) << 20) | f | (32'(rd) << 7) | 32'h03;
      3: return (((x >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | f | ((x & 32'h1F) << 7) | 32'h23;
      4: return (((x >> 12) & 1) << 31) | (((x >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | f
                | (((x >> 1) & 32'hF) << 8) | (((x >> 11) & 1) << 7) | 32'h63;
      5: return (((x >> 20) & 1) << 31) | (((x >> 1) & 32'h3FF) << 21) | (((x >> 11) & 1) << 20)
                | (((x >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
      6: return ((x & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_rej();
    int s;
    s = int'($signed(imm));
    if (cls == 7) return 1;
`ifdef IMM_RANGE_CHECK_EN
    if (cls inside {1, 2, 3, 6} && (s < -2048 || s > 2047)) return 1;
    if (cls == 4 && (s < -4096 || s > 4095 || s % 2 != 0)) return 1;
    if (cls == 5 && s % 2 != 0) return 1;
    if (cls == 1 && (f3 == 1 || f3 == 5) && (s < 0 || s > 31)) return 1;
`endif
    return 0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic set(input bit v, input int c, input int f, input bit al, input int d, input int s1,
                     input int s2, input int im);
    in_valid = v; cls = 3'(c); f3 = 3'(f); alt = al; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 21'(im);
  endtask

  task automatic cyc(input bit use_want = 0, input logic [31:0] want = 0);
    bit acc, rej;
    @(posedge clk);
    if (rst) begin
      q.delete(); mcount = 0; maddr = BASE; exp_cnt = 0; exp_err = 0;
    end else if (flush) begin
      q.delete(); mcount = 0; maddr = BASE; exp_err = 0;
    end else begin
      acc = in_valid && mcount != DEPTH;
      rej = acc && ref_rej();
      exp_err = rej;
      if (rej && exp_cnt != 255) exp_cnt++;
      if (pop_now) mcount--;
      if (acc && !rej) begin
        q.push_back('{a: maddr, d: use_want ? want : ref_enc()});
        maddr += 4;
        mcount++;
      end
    end
    started = 1;
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1; in_valid = 0; cyc(); rst = 0;
  endtask

  always @(negedge clk) if (started) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
    chk("err", 32'(err), 32'(exp_err));
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_addr", out_addr, q[0].a);
    end else begin
      chk("idle_data", out_data, 0);
      chk("idle_addr", out_addr, 0);
    end
    pop_now = q.size() != 0 && out_ready;
    if (pop_now) void'(q.pop_front());
  end

  initial begin
    cyc(); cyc(); rst = 0;
    set(1, 0, 0, 0, 3, 1, 2, 0); cyc(1, 32'h002081B3);
    in_valid = 0; cyc(); cyc();
    reset_pulse();
    set(1, 1, 0, 0, 1, 0, 0, 5); cyc(1, 32'h00500093);
    set(1, 4, 0, 0, 0, 1, 2, 8); cyc(1, 32'h00208463);
    in_valid = 0; cyc(); cyc(); cyc();
    reset_pulse();
    set(1, 5, 0, 0, 1, 0, 0, 16); cyc(1, 32'h010000EF);
    set(1, 3, 2, 0, 0, 1, 2, 4); cyc(1, 32'h0020A223);
    in_valid = 0; cyc(); cyc(); cyc();
    reset_pulse();
    out_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      set(1, 0, 0, i[0], i + 1, 1, 2, 0); cyc();
    end
    in_valid = 0; cyc(); out_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) cyc();
    reset_pulse();
    set(1, 7, 0, 0, 1, 1, 1, 0); cyc();
    in_valid = 0; cyc();
    set(1, 0, 0, 1, 5, 6, 7, 0); cyc();
    set(1, 1, 0, 0, 1, 0, 0, 2048); cyc();
    in_valid = 0; cyc(); cyc(); cyc();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set(1, 2, 2, 0, i, 1, 0, 4 * i); cyc();
    end
    flush = 1; set(1, 0, 0, 0, 9, 9, 9, 0); cyc();
    flush = 0; set(1, 6, 3, 0, 1, 2, 0, -4); cyc();
    in_valid = 0; cyc(); out_ready = 1; cyc(); cyc();
    for (int i = 0; i < 1500; i++) begin
      set($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 63) - 32);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    cyc();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d words left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
